tlb_walk_controller: RTL

- Hardware page-table walker that services TLB misses for the pipelined core.
- On a miss it stalls the pipeline and fetches ARM short-format descriptors from memory: L1, then L2 when the L1 descriptor points to a coarse table.
- It then writes a 4 KB-granular entry into the TLB using round-robin replacement, or raises a translation fault.
- It sits between the TLB, the memory arbiter and hazard control.

---
 rtl/tlb_pkg.sv | 25 ++
 rtl/tlb_desc_decode.sv | 48 ++++
 rtl/tlb_walk_controller.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/tlb_pkg.sv
// Shared types and constants for the TLB page-table walker.
// Covers ARM short-format descriptors: L1 section/coarse and L2 small/large pages.
package tlb_pkg;

    localparam int unsigned DEFAULT_SIZE    = 16;
    localparam int unsigned DEFAULT_TAGBITS = 20;

    localparam logic [1:0] DESC_FAULT   = 2'b00;
    localparam logic [1:0] DESC_COARSE  = 2'b01;
    localparam logic [1:0] DESC_SECTION = 2'b10;
    localparam logic [1:0] DESC_RSVD    = 2'b11;

    localparam logic [3:0] FSR_TRANS_SECTION = 4'b0101;
    localparam logic [3:0] FSR_TRANS_PAGE    = 4'b0111;

    typedef enum logic [2:0] {
        StIdle,
        StL1,
        StL2,
        StFill,
        StFault,
        StAbort
    } walk_state_e;

endpackage

// File: rtl/tlb_desc_decode.sv
// Combinational decode of one fetched descriptor into a fill, a next-level fetch or a fault.
// At L2 the encodings 10 and 01 mean small and large pages, not section and coarse.
module tlb_desc_decode
    import tlb_pkg::*;
(
    input  logic        level_l2_i,
    input  logic [1:0]  desc_type_i,
    input  logic [21:0] desc_hi_i,    // descriptor bits [31:10]
    input  logic [7:0]  va_idx_i,     // VA[19:12]
    output logic        fill_o,
    output logic        next_o,
    output logic [21:0] next_base_o,
    output logic [19:0] phys_page_o,
    output logic [3:0]  fault_status_o
);

    assign next_base_o = desc_hi_i;

    always_comb begin
        fill_o         = 1'b0;
        next_o         = 1'b0;
        phys_page_o    = '0;
        fault_status_o = '0;
        if (!level_l2_i) begin
            unique case (desc_type_i)
                DESC_SECTION: begin
                    fill_o      = 1'b1;
                    phys_page_o = {desc_hi_i[21:10], va_idx_i};
                end
                DESC_COARSE: next_o = 1'b1;
                default:     fault_status_o = FSR_TRANS_SECTION;
            endcase
        end else begin
            unique case (desc_type_i)
                DESC_SECTION: begin
                    fill_o      = 1'b1;
                    phys_page_o = desc_hi_i[21:2];
                end
                DESC_COARSE: begin
                    fill_o      = 1'b1;
                    phys_page_o = {desc_hi_i[21:6], va_idx_i[3:0]};
                end
                default: fault_status_o = FSR_TRANS_PAGE;
            endcase
        end
    end

endmodule

// File: rtl/tlb_walk_controller.sv
// Hardware page-table walker: services TLB misses by fetching L1/L2 descriptors, stalls the
// pipeline meanwhile, and fills the TLB round-robin or reports a translation fault.
module tlb_walk_controller
    import tlb_pkg::*;
#(
    parameter int unsigned size    = DEFAULT_SIZE,
    parameter int unsigned tagbits = DEFAULT_TAGBITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    Miss,
    input  logic                    Flush,
    input  logic [31:0]             VirtAdr,
    input  logic [17:0]             TTBR,
    output logic                    MemRE,
    output logic [31:0]             MemAdr,
    input  logic [31:0]             MemRData,
    input  logic                    MemReady,
    output logic                    TLBWe,
    output logic [$clog2(size)-1:0] TLBWay,
    output logic [tagbits-1:0]      TLBTag,
    output logic [19:0]             TLBPhysPage,
    output logic                    Stall,
    output logic                    Fault,
    output logic [3:0]              FaultStatus
);

    localparam int unsigned WayW = $clog2(size);

    walk_state_e       state_q, state_d;
    logic [19:0]       va_q, va_d;        // VA[31:12] of the walk in progress
    logic [31:0]       adr_q, adr_d;
    logic [19:0]       phys_q, phys_d;
    logic [WayW-1:0]   ptr_q, ptr_d;
    logic [3:0]        fsr_q, fsr_d;

    logic              accept;
    logic              dec_fill;
    logic              dec_next;
    logic [21:0]       dec_next_base;
    logic [19:0]       dec_phys;
    logic [3:0]        dec_fsr;

    logic              unused_bits;
    assign unused_bits = ^{VirtAdr[11:0], MemRData[9:2]};

    tlb_desc_decode u_decode (
        .level_l2_i    (state_q == StL2),
        .desc_type_i   (MemRData[1:0]),
        .desc_hi_i     (MemRData[31:10]),
        .va_idx_i      (va_q[7:0]),
        .fill_o        (dec_fill),
        .next_o        (dec_next),
        .next_base_o   (dec_next_base),
        .phys_page_o   (dec_phys),
        .fault_status_o(dec_fsr)
    );

    assign accept = (state_q == StIdle) & enable & Miss & ~Flush;

    always_comb begin
        state_d = state_q;
        va_d    = va_q;
        adr_d   = adr_q;
        phys_d  = phys_q;
        ptr_d   = ptr_q;
        fsr_d   = fsr_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StL1;
                    va_d    = VirtAdr[31:12];
                    adr_d   = {TTBR, VirtAdr[31:20], 2'b00};
                end
            end
            StL1, StL2: begin
                if (MemReady) begin
                    // A flush landing with the response drops the data outright.
                    if (Flush) begin
                        state_d = StIdle;
                    end else if (dec_fill) begin
                        state_d = StFill;
                        phys_d  = dec_phys;
                    end else if (dec_next) begin
                        state_d = StL2;
                        adr_d   = {dec_next_base, va_q[7:0], 2'b00};
                    end else begin
                        state_d = StFault;
                        fsr_d   = dec_fsr;
                    end
                end else if (Flush) begin
                    state_d = StAbort;
                end
            end
            StAbort: begin
                if (MemReady) begin
                    state_d = StIdle;
                end
            end
            StFill: begin
                state_d = StIdle;
                ptr_d   = (ptr_q == WayW'(size - 1)) ? '0 : ptr_q + 1'b1;
            end
            StFault: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            va_q    <= '0;
            adr_q   <= '0;
            phys_q  <= '0;
            ptr_q   <= '0;
            fsr_q   <= '0;
        end else begin
            state_q <= state_d;
            va_q    <= va_d;
            adr_q   <= adr_d;
            phys_q  <= phys_d;
            ptr_q   <= ptr_d;
            fsr_q   <= fsr_d;
        end
    end

    // Abort keeps the request up until the bus completes it.
    always_comb begin
        MemRE       = (state_q == StL1) | (state_q == StL2) | (state_q == StAbort);
        MemAdr      = MemRE ? adr_q : '0;
        TLBWe       = (state_q == StFill);
        TLBWay      = TLBWe ? ptr_q : '0;
        TLBTag      = TLBWe ? va_q[19 -: tagbits] : '0;
        TLBPhysPage = TLBWe ? phys_q : '0;
        Fault       = (state_q == StFault);
        FaultStatus = fsr_q;
        Stall       = (state_q != StIdle) | accept;
    end

endmodule
